rv32m_divider: RTL and testbench
================================

RV32M_DIVIDER -- requirements
Module: rv32m_divider

Interface
REQ-001 Parameter: none; datapath width fixed at 32 bits.
REQ-002 I_CLK  input  1  single clock, all state on rising edge.
REQ-003 I_RSTN  input  1  reset, asynchronous, active-low.
REQ-004 I_START  input  1  request; accepted only in IDLE or DONE.
REQ-005 I_OP_A  input  32  dividend, captured on the accepting edge.
REQ-006 I_OP_B  input  32  divisor, captured on the accepting edge.
REQ-007 I_OP_TYPE  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; captured on the accepting edge.
REQ-008 O_BUSY  output  1  high while in CALC or FIX.
REQ-009 O_DONE  output  1  one-cycle pulse, high only in DONE.
REQ-010 O_RESULT  output  32  quotient or remainder, registered.

Function
REQ-011 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-012 Accepting edge, normal case: IDLE/DONE->CALC; load |A| and |B| (signed ops) or raw values (unsigned), clear remainder, iteration counter = 0.
REQ-013 CALC SHALL run exactly 32 restoring iterations, one per edge, MSB first: shift {rem,quo} left 1; trial-subtract 33-bit; if non-negative keep difference and set quo bit 0.
REQ-014 After the 32nd iteration the FSM SHALL move to FIX; the FIX edge applies signs, loads O_RESULT and moves to DONE.
REQ-015 Sign rules: DIV quotient negated iff operand signs differ; REM remainder takes the dividend sign; DIVU/REMU unsigned.
REQ-016 Normal latency: accepting edge = edge 1; O_DONE high between edge 34 and edge 35.
REQ-017 Divide by zero (I_OP_B = 0): accepting edge goes directly to DONE; DIV/DIVU result 0xFFFFFFFF; REM/REMU result = I_OP_A.
REQ-018 Signed overflow (DIV/REM, A = 0x80000000, B = 0xFFFFFFFF): direct to DONE; DIV result 0x80000000, REM result 0x00000000.
REQ-019 Fast-path latency: O_DONE high between edge 1 and edge 2.
REQ-020 DONE SHALL last one cycle, then go to IDLE, unless I_START is high, which is accepted as a new request (back-to-back).
REQ-021 I_START in CALC or FIX SHALL be ignored with no effect on the operation in flight.
REQ-022 Input changes after the accepting edge SHALL NOT affect the result.
REQ-023 O_RESULT SHALL hold its last value until the FIX or fast-path edge of the next operation.

Reset
REQ-024 While I_RSTN is low, FSM = IDLE, O_BUSY = 0, O_DONE = 0, O_RESULT = 0, counter and internal registers = 0, independent of I_CLK.
REQ-025 Reset during CALC or FIX SHALL abort the operation with no O_DONE pulse; the first accepting edge after release starts a clean operation.

Structure
REQ-026 The op-type codes (DIV, DIVU, REM, REMU) and FSM state encoding SHALL live in the shared package rv32i_pkg.
REQ-027 The 33-bit trial subtraction SHALL use the codebase's RCA_32 adder (with a carry extension) as the only sub-module; the rest is flat RTL.

Verification
REQ-028 DIVU A=100, B=7 -> O_RESULT 14 with O_DONE at edge 34; REMU same operands -> 2.
REQ-029 DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-030 DIV A=5, B=0 -> 0xFFFFFFFF at edge 1; REMU A=5, B=0 -> 5; O_BUSY never asserted.
REQ-031 DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM same operands -> 0; O_DONE at edge 1.
REQ-032 Start DIVU 0xFFFFFFFF/3, toggle I_START and operands during CALC, then assert I_RSTN low at edge 10 -> outputs 0 immediately, no O_DONE; restart DIVU after release -> 0x55555555.
REQ-033 I_START held high through DONE with a second op (REMU 10/4) -> second op accepted at the DONE edge, results 0x55555555 then 2 with no idle cycle.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32M divide unit: operation codes, FSM state
// encoding and small helpers used when capturing operands.
package rv32i_pkg;

  // Operation codes carried on I_OP_TYPE
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // Divider FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Signed variants take operand magnitudes and fix signs at the end
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Remainder variants return the remainder register instead of the quotient
  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude 2^31
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/rv32m_divider_rca_32.sv
// RCA_32: 32-bit ripple-carry adder with carry in and carry out.
module RCA_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_i,
  output logic [31:0] sum_o,
  output logic        c_o
);

  logic [32:0] carry;

  assign carry[0] = c_i;

  // One full adder per bit, carry rippling from bit 0 upwards
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_fa
      assign sum_o[gi]    = a_i[gi] ^ b_i[gi] ^ carry[gi];
      assign carry[gi+1]  = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
    end
  endgenerate

  assign c_o = carry[32];

endmodule

// File: rtl/rv32m_divider.sv
// rv32m_divider: multi-cycle RV32M DIV/DIVU/REM/REMU unit. A restoring
// divider runs 32 iterations on operand magnitudes, then a FIX cycle applies
// signs. Divide-by-zero and signed overflow bypass the iterations.
module rv32m_divider
  import rv32i_pkg::*;
(
  input  logic        I_CLK,
  input  logic        I_RSTN,
  input  logic        I_START,
  input  logic [31:0] I_OP_A,
  input  logic [31:0] I_OP_B,
  input  logic [1:0]  I_OP_TYPE,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic [31:0] O_RESULT
);

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  op_q, op_d;
  logic        neg_q, neg_d;

  logic        accept;
  logic        div_zero;
  logic        overflow;
  logic [31:0] fast_result;
  logic [31:0] trial_a;
  logic [31:0] trial_diff;
  logic        trial_carry;
  logic        trial_ge;
  logic [31:0] fix_mag;

  assign accept   = I_START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign div_zero = (I_OP_B == 32'd0);
  assign overflow = op_is_signed(I_OP_TYPE) && (I_OP_A == 32'h8000_0000) &&
                    (I_OP_B == 32'hFFFF_FFFF);

  // Shifted partial remainder: {rem, quo} << 1 exposes rem[31] as bit 32 and
  // quo[31] as the new bit 0 of the 33-bit trial value.
  assign trial_a = {rem_q[30:0], quo_q[31]};

  RCA_32 u_trial_sub (
    .a_i   (trial_a),
    .b_i   (~dvsr_q),
    .c_i   (1'b1),
    .sum_o (trial_diff),
    .c_o   (trial_carry)
  );

  // Carry extension to 33 bits: the divisor's bit 32 is zero (inverted to one),
  // so the carry out of bit 32 is rem[31] | carry; carry set means no borrow,
  // i.e. the difference is non-negative. The kept difference is always < divisor
  // and therefore fits in the low 32 bits.
  assign trial_ge = rem_q[31] | trial_carry;

  assign fix_mag = op_is_rem(op_q) ? rem_q : quo_q;

  // Result for the operations that skip the iterative path
  always_comb begin
    fast_result = 32'd0;
    if (div_zero) begin
      fast_result = op_is_rem(I_OP_TYPE) ? I_OP_A : 32'hFFFF_FFFF;
    end else begin
      fast_result = op_is_rem(I_OP_TYPE) ? 32'd0 : 32'h8000_0000;
    end
  end

  // Next-state and datapath update for all FSM states
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;
    op_d     = op_q;
    neg_d    = neg_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (div_zero || overflow) begin
            state_d  = ST_DONE;
            result_d = fast_result;
          end else begin
            state_d = ST_CALC;
            cnt_d   = 5'd0;
            rem_d   = 32'd0;
            op_d    = I_OP_TYPE;
            if (op_is_signed(I_OP_TYPE)) begin
              quo_d  = abs32(I_OP_A);
              dvsr_d = abs32(I_OP_B);
              neg_d  = op_is_rem(I_OP_TYPE) ? I_OP_A[31] : (I_OP_A[31] ^ I_OP_B[31]);
            end else begin
              quo_d  = I_OP_A;
              dvsr_d = I_OP_B;
              neg_d  = 1'b0;
            end
          end
        end
      end
      ST_CALC: begin
        rem_d = trial_ge ? trial_diff : trial_a;
        quo_d = {quo_q[30:0], trial_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d = neg_q ? (32'd0 - fix_mag) : fix_mag;
        state_d  = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvsr_q   <= 32'd0;
      result_q <= 32'd0;
      op_q     <= 2'd0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
    end
  end

  assign O_BUSY   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign O_DONE   = (state_q == ST_DONE);
  assign O_RESULT = result_q;

endmodule

// File: tb/tb_rv32m_divider.sv
// Self-checking bench for rv32m_divider: directed cases, randomized ops
// against an arithmetic reference model, reset abort and back-to-back issue.
module tb_rv32m_divider;

  logic        I_CLK = 1'b0;
  logic        I_RSTN = 1'b1;
  logic        I_START = 1'b0;
  logic [31:0] I_OP_A = 32'd0;
  logic [31:0] I_OP_B = 32'd0;
  logic [1:0]  I_OP_TYPE = 2'd0;
  logic        O_BUSY;
  logic        O_DONE;
  logic [31:0] O_RESULT;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] last_res = 32'd0;

  rv32m_divider dut (
    .I_CLK     (I_CLK),
    .I_RSTN    (I_RSTN),
    .I_START   (I_START),
    .I_OP_A    (I_OP_A),
    .I_OP_B    (I_OP_B),
    .I_OP_TYPE (I_OP_TYPE),
    .O_BUSY    (O_BUSY),
    .O_DONE    (O_DONE),
    .O_RESULT  (O_RESULT)
  );

  always #5 I_CLK = ~I_CLK;

  // Reference model: RISC-V M-extension division semantics in plain arithmetic
  function automatic logic [31:0] model_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [1:0] op);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      2'b00: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      2'b01: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      2'b10: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_latency(input logic [31:0] a, input logic [31:0] b,
                                       input logic [1:0] op);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issues one op and waits for O_DONE; returns observations only
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input bit noise, output logic [31:0] res, output int lat,
                        output bit busy_ok, output logic [31:0] res_mid);
    int k;
    I_OP_A = a;
    I_OP_B = b;
    I_OP_TYPE = op;
    I_START = 1'b1;
    @(posedge I_CLK); #1;
    I_START = 1'b0;
    I_OP_A = $urandom;
    I_OP_B = $urandom;
    I_OP_TYPE = 2'($urandom);
    res_mid = O_RESULT;
    busy_ok = 1'b1;
    lat = 0;
    k = 1;
    while (lat == 0 && k <= 50) begin
      if (O_DONE) begin
        lat = k;
      end else begin
        if (!O_BUSY) busy_ok = 1'b0;
        if (noise) begin
          I_START = 1'($urandom);
          I_OP_A = $urandom;
          I_OP_B = $urandom;
          I_OP_TYPE = 2'($urandom);
        end
        @(posedge I_CLK); #1;
        k++;
      end
    end
    I_START = 1'b0;
    res = O_RESULT;
  endtask

  task automatic test_reset();
    #1 I_RSTN = 1'b0;
    #1;
    n_checks++;
    if ({O_BUSY, O_DONE, O_RESULT} !== 34'd0)
      $display("FAIL reset_async busy=%b done=%b result=%h required 0/0/0", O_BUSY, O_DONE, O_RESULT);
    else n_pass++;
    repeat (2) @(posedge I_CLK);
    #1;
    n_checks++;
    if ({O_BUSY, O_DONE, O_RESULT} !== 34'd0)
      $display("FAIL reset_held busy=%b done=%b result=%h required 0/0/0", O_BUSY, O_DONE, O_RESULT);
    else n_pass++;
    I_RSTN = 1'b1;
    @(posedge I_CLK); #1;
    n_checks++;
    if ({O_BUSY, O_DONE} !== 2'b00)
      $display("FAIL idle_after_reset busy=%b done=%b required 0/0", O_BUSY, O_DONE);
    else n_pass++;
    last_res = 32'd0;
  endtask

  task automatic test_directed();
    logic [31:0] ta [8];
    logic [31:0] tb [8];
    logic [1:0]  top [8];
    logic [31:0] texp [8];
    int          tlat [8];
    logic [31:0] res;
    logic [31:0] res_mid;
    int          lat;
    bit          busy_ok;
    ta   = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    tb   = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    top  = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10};
    texp = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    tlat = '{34, 34, 34, 34, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb[i], top[i], 1'b0, res, lat, busy_ok, res_mid);
      $display("directed op=%0d a=%h b=%h result=%h latency=%0d", top[i], ta[i], tb[i], res, lat);
      n_checks++;
      if (res !== texp[i]) $display("FAIL directed_%0d result got=%h required=%h", i, res, texp[i]);
      else n_pass++;
      n_checks++;
      if (lat != tlat[i]) $display("FAIL directed_%0d latency got=%0d required=%0d", i, lat, tlat[i]);
      else n_pass++;
      n_checks++;
      if (O_BUSY !== 1'b0) $display("FAIL directed_%0d busy_in_done got=%b required=0", i, O_BUSY);
      else n_pass++;
      if (tlat[i] == 34) begin
        n_checks++;
        if (!busy_ok) $display("FAIL directed_%0d busy_during_calc got=0 required=1", i);
        else n_pass++;
        n_checks++;
        if (res_mid !== last_res)
          $display("FAIL directed_%0d result_hold got=%h required=%h", i, res_mid, last_res);
        else n_pass++;
      end
      last_res = texp[i];
      @(posedge I_CLK); #1;
      n_checks++;
      if (O_DONE !== 1'b0 || O_BUSY !== 1'b0 || O_RESULT !== texp[i])
        $display("FAIL directed_%0d after_done done=%b busy=%b result=%h required 0/0/%h",
                 i, O_DONE, O_BUSY, O_RESULT, texp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp_res;
    int          exp_lat;
    logic [31:0] res;
    logic [31:0] res_mid;
    int          lat;
    bit          busy_ok;
    bit          noise;
    int          sel;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      sel = $urandom_range(0, 7);
      a = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 300);
      if ($urandom_range(0, 3) == 0) a = -a;
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2, 3: b = $urandom_range(1, 16);
        4: b = -$urandom_range(1, 16);
        default: b = $urandom;
      endcase
      noise = 1'($urandom);
      exp_res = model_result(a, b, op);
      exp_lat = model_latency(a, b, op);
      run_op(a, b, op, noise, res, lat, busy_ok, res_mid);
      $display("random op=%0d a=%h b=%h noise=%0d result=%h latency=%0d", op, a, b, noise, res, lat);
      n_checks++;
      if (res !== exp_res) $display("FAIL random_%0d result got=%h required=%h", i, res, exp_res);
      else n_pass++;
      n_checks++;
      if (lat != exp_lat) $display("FAIL random_%0d latency got=%0d required=%0d", i, lat, exp_lat);
      else n_pass++;
      if (exp_lat == 34) begin
        n_checks++;
        if (!busy_ok) $display("FAIL random_%0d busy_during_calc got=0 required=1", i);
        else n_pass++;
        n_checks++;
        if (res_mid !== last_res)
          $display("FAIL random_%0d result_hold got=%h required=%h", i, res_mid, last_res);
        else n_pass++;
      end
      last_res = exp_res;
      @(posedge I_CLK); #1;
      n_checks++;
      if (O_DONE !== 1'b0 || O_RESULT !== exp_res)
        $display("FAIL random_%0d after_done done=%b result=%h required 0/%h", i, O_DONE, O_RESULT, exp_res);
      else n_pass++;
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] res;
    logic [31:0] res_mid;
    int          lat;
    bit          busy_ok;
    int          done_seen;
    I_OP_A = 32'hFFFF_FFFF;
    I_OP_B = 32'd3;
    I_OP_TYPE = 2'b01;
    I_START = 1'b1;
    @(posedge I_CLK); #1;
    for (int k = 2; k <= 10; k++) begin
      I_START = 1'($urandom);
      I_OP_A = $urandom;
      I_OP_B = $urandom;
      I_OP_TYPE = 2'($urandom);
      @(posedge I_CLK); #1;
    end
    n_checks++;
    if (O_BUSY !== 1'b1) $display("FAIL abort_busy_before got=%b required=1", O_BUSY);
    else n_pass++;
    I_RSTN = 1'b0;
    #1;
    n_checks++;
    if ({O_BUSY, O_DONE, O_RESULT} !== 34'd0)
      $display("FAIL abort_async busy=%b done=%b result=%h required 0/0/0", O_BUSY, O_DONE, O_RESULT);
    else n_pass++;
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      I_START = 1'($urandom);
      @(posedge I_CLK); #1;
      if (O_DONE || O_BUSY) done_seen++;
    end
    I_START = 1'b0;
    I_RSTN = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge I_CLK); #1;
      if (O_DONE || O_BUSY) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) $display("FAIL abort_no_done activity_cycles=%0d required=0", done_seen);
    else n_pass++;
    last_res = 32'd0;
    run_op(32'hFFFF_FFFF, 32'd3, 2'b01, 1'b0, res, lat, busy_ok, res_mid);
    $display("abort_restart op=1 a=ffffffff b=00000003 result=%h latency=%0d", res, lat);
    n_checks++;
    if (res !== 32'h5555_5555 || lat != 34)
      $display("FAIL abort_restart result=%h latency=%0d required 55555555/34", res, lat);
    else n_pass++;
    n_checks++;
    if (res_mid !== 32'd0) $display("FAIL abort_restart_hold got=%h required=00000000", res_mid);
    else n_pass++;
    last_res = 32'h5555_5555;
    @(posedge I_CLK); #1;
  endtask

  task automatic test_back_to_back();
    int lat1;
    int lat2;
    logic [31:0] res1;
    I_OP_A = 32'hFFFF_FFFF;
    I_OP_B = 32'd3;
    I_OP_TYPE = 2'b01;
    I_START = 1'b1;
    @(posedge I_CLK); #1;
    I_OP_A = 32'd10;
    I_OP_B = 32'd4;
    I_OP_TYPE = 2'b11;
    lat1 = 0;
    for (int k = 1; k <= 50 && lat1 == 0; k++) begin
      if (O_DONE) lat1 = k;
      else begin
        @(posedge I_CLK); #1;
      end
    end
    res1 = O_RESULT;
    $display("b2b first op=1 result=%h latency=%0d", res1, lat1);
    n_checks++;
    if (res1 !== 32'h5555_5555 || lat1 != 34)
      $display("FAIL b2b_first result=%h latency=%0d required 55555555/34", res1, lat1);
    else n_pass++;
    @(posedge I_CLK); #1;
    I_START = 1'b0;
    n_checks++;
    if (O_BUSY !== 1'b1 || O_DONE !== 1'b0 || O_RESULT !== 32'h5555_5555)
      $display("FAIL b2b_no_idle busy=%b done=%b result=%h required 1/0/55555555", O_BUSY, O_DONE, O_RESULT);
    else n_pass++;
    lat2 = 0;
    for (int k = 1; k <= 50 && lat2 == 0; k++) begin
      if (O_DONE) lat2 = k;
      else begin
        @(posedge I_CLK); #1;
      end
    end
    $display("b2b second op=3 result=%h latency=%0d", O_RESULT, lat2);
    n_checks++;
    if (O_RESULT !== 32'd2 || lat2 != 34)
      $display("FAIL b2b_second result=%h latency=%0d required 00000002/34", O_RESULT, lat2);
    else n_pass++;
    @(posedge I_CLK); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
